// File: rtl/bram_rd_pkg.sv
// Shared widths and FSM state type for the BRAM read-side streamer.
package bram_rd_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 13;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

endpackage

// File: rtl/bram_rd_streamer_if.sv
// BRAM read port plus downstream byte stream, bundled for the streamer.
// master = streamer side, slave = BRAM model / consumer side.
interface bram_rd_streamer_if;
    import bram_rd_pkg::*;

    logic [ADDR_W-1:0] rdaddr;
    logic              rden;
    logic              regce;
    logic [DATA_W-1:0] bram_do;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    modport master (
        output rdaddr, rden, regce, m_data, m_valid,
        input  bram_do, m_ready
    );

    modport slave (
        input  rdaddr, rden, regce, m_data, m_valid,
        output bram_do, m_ready
    );

endinterface

// File: rtl/bram_rd_fifo.sv
// Small synchronous byte FIFO absorbing BRAM read latency.
// Head reads as zero while empty so the stream data output is clean after reset.
module bram_rd_fifo
    import bram_rd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              full;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so push is legal even when full.
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bram_rd_streamer.sv
// Drains the 8-bit BRAM read port into a valid/ready byte stream using credit-tracked reads.
// Optional running checksum output enabled by defining BRAM_RD_CHKSUM_EN.
module bram_rd_streamer
    import bram_rd_pkg::*;
#(
    parameter int DO_REG     = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                rdclk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [LEN_W-1:0]    len,
    bram_rd_streamer_if.master  bus,
    output logic                busy,
    output logic                done
`ifdef BRAM_RD_CHKSUM_EN
    ,
    output logic [DATA_W-1:0]   chksum
`endif
);

    localparam int LAT   = 1 + DO_REG;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W = CNT_W + 2;

    state_t             state;
    logic [ADDR_W-1:0]  rdaddr;
    logic               rden;
    logic [LEN_W-1:0]   issue_left;
    logic [LAT-1:0]     lat_sr;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_empty;
    logic [DATA_W-1:0]  fifo_head;
    logic               push;
    logic               pop;
    logic [OCC_W-1:0]   occupancy;
    logic               credit_ok;

    assign push        = lat_sr[LAT-1];
    assign pop         = bus.m_ready & ~fifo_empty;
    assign bus.rdaddr  = rdaddr;
    assign bus.rden    = rden;
    assign bus.regce   = (DO_REG != 0);
    assign bus.m_valid = ~fifo_empty;
    assign bus.m_data  = fifo_head;

    // Slots committed after this edge: stored bytes, reads still in the BRAM pipe
    // and the read on the port now, less the byte leaving this edge.
    always_comb begin
        occupancy = OCC_W'(fifo_count) + OCC_W'(rden);
        for (int i = 0; i < LAT; i++) begin
            occupancy = occupancy + OCC_W'(lat_sr[i]);
        end
        occupancy = occupancy - OCC_W'(pop);
    end

    assign credit_ok = (occupancy < OCC_W'(FIFO_DEPTH));

    always_ff @(posedge rdclk or negedge rst_n) begin
        if (!rst_n) begin
            lat_sr <= '0;
        end else begin
            lat_sr <= (lat_sr << 1) | LAT'(rden);
        end
    end

    always_ff @(posedge rdclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rdaddr     <= '0;
            rden       <= 1'b0;
            issue_left <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (rden) begin
                rdaddr <= rdaddr + ADDR_W'(1);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            state      <= ISSUE;
                            rdaddr     <= base_addr;
                            rden       <= 1'b1;
                            issue_left <= len - LEN_W'(1);
                            busy       <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (issue_left == '0) begin
                        rden  <= 1'b0;
                        state <= DRAIN;
                    end else if (credit_ok) begin
                        rden       <= 1'b1;
                        issue_left <= issue_left - LEN_W'(1);
                    end else begin
                        rden <= 1'b0;
                    end
                end
                DRAIN: begin
                    // Nothing left in the pipe and the last stored byte leaves now.
                    if (pop && fifo_count == CNT_W'(1) && lat_sr == '0) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    rden  <= 1'b0;
                end
            endcase
        end
    end

`ifdef BRAM_RD_CHKSUM_EN
    always_ff @(posedge rdclk or negedge rst_n) begin
        if (!rst_n) begin
            chksum <= '0;
        end else if (state == IDLE && start) begin
            chksum <= '0;
        end else if (pop) begin
            chksum <= chksum + fifo_head;
        end
    end
`endif

    bram_rd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (rdclk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (bus.bram_do),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_bram_rd_streamer.sv
// Directed bench for bram_rd_streamer: one DUT per DO_REG setting, each with its own BRAM model.
// Checksum checks are compiled in when BRAM_RD_CHKSUM_EN is defined.
`timescale 1ns/1ps
module tb_bram_rd_streamer;
    import bram_rd_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              sel;
    logic              start;
    logic              start0;
    logic              start1;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  len;
    logic              m_ready;
    logic              busy0, busy1, done0, done1;
`ifdef BRAM_RD_CHKSUM_EN
    logic [DATA_W-1:0] chk0, chk1, mon_chk;
`endif

    bram_rd_streamer_if bus0();
    bram_rd_streamer_if bus1();

    logic [7:0] mem [4096];
    logic [7:0] do0_q, do1_a, do1_b;

    function automatic logic [7:0] mem_byte(input logic [11:0] a);
        return a[7:0] ^ {a[11:8], 4'h0};
    endfunction

    // BRAM read ports: plain latch for instance 0, extra output register for instance 1.
    always @(posedge clk) begin
        if (bus0.rden) do0_q <= mem[bus0.rdaddr];
        if (bus1.rden) do1_a <= mem[bus1.rdaddr];
        if (bus1.regce) do1_b <= do1_a;
    end

    assign bus0.bram_do = do0_q;
    assign bus1.bram_do = do1_b;
    assign bus0.m_ready = m_ready;
    assign bus1.m_ready = m_ready;
    assign start0 = start & ~sel;
    assign start1 = start & sel;

    bram_rd_streamer #(.DO_REG(0), .FIFO_DEPTH(DEPTH)) dut0 (
        .rdclk(clk), .rst_n(rst_n), .start(start0), .base_addr(base_addr), .len(len),
        .bus(bus0), .busy(busy0), .done(done0)
`ifdef BRAM_RD_CHKSUM_EN
        , .chksum(chk0)
`endif
    );

    bram_rd_streamer #(.DO_REG(1), .FIFO_DEPTH(DEPTH)) dut1 (
        .rdclk(clk), .rst_n(rst_n), .start(start1), .base_addr(base_addr), .len(len),
        .bus(bus1), .busy(busy1), .done(done1)
`ifdef BRAM_RD_CHKSUM_EN
        , .chksum(chk1)
`endif
    );

    logic [11:0] mon_rdaddr;
    logic        mon_rden, mon_regce, mon_mvalid, mon_busy, mon_done;
    logic [7:0]  mon_mdata;
    assign mon_rdaddr = sel ? bus1.rdaddr  : bus0.rdaddr;
    assign mon_rden   = sel ? bus1.rden    : bus0.rden;
    assign mon_regce  = sel ? bus1.regce   : bus0.regce;
    assign mon_mvalid = sel ? bus1.m_valid : bus0.m_valid;
    assign mon_mdata  = sel ? bus1.m_data  : bus0.m_data;
    assign mon_busy   = sel ? busy1 : busy0;
    assign mon_done   = sel ? done1 : done0;
`ifdef BRAM_RD_CHKSUM_EN
    assign mon_chk    = sel ? chk1 : chk0;
`endif

    int checks = 0;
    int failures = 0;

    logic [7:0]  got_q[$];
    logic [11:0] addr_q[$];
    int first_valid, done_cyc, busy_cyc, credit_viol, regce_bad;
    bit timed_out;

    // Starts one transfer on the selected DUT and records what it does until DONE.
    task automatic run_xfer(input logic [11:0] b, input logic [12:0] n, input bit rand_ready,
                            input bit poke_start, input int budget);
        int cyc, issued, popped;
        got_q.delete();
        addr_q.delete();
        first_valid = -1; done_cyc = -1; busy_cyc = 0; credit_viol = 0; regce_bad = 0;
        timed_out = 1'b0; issued = 0; popped = 0;
        base_addr = b; len = n; start = 1'b1; m_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; base_addr = 12'hABC; len = 13'd7;
        cyc = 1;
        while (done_cyc < 0 && !timed_out) begin
            m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (poke_start) start = (cyc == 6);
            if (mon_regce !== (sel ? 1'b1 : 1'b0)) regce_bad++;
            if (mon_rden === 1'b1) begin
                issued++;
                addr_q.push_back(mon_rdaddr);
                if (issued - popped > DEPTH) credit_viol++;
            end
            if (mon_mvalid === 1'b1 && first_valid < 0) first_valid = cyc;
            if (mon_mvalid === 1'b1 && m_ready) begin
                got_q.push_back(mon_mdata);
                popped++;
            end
            if (mon_busy === 1'b1) busy_cyc++;
            if (mon_done === 1'b1) done_cyc = cyc;
            if (done_cyc < 0) begin
                if (cyc >= budget) timed_out = 1'b1;
                else begin
                    @(posedge clk); #1;
                    cyc++;
                end
            end
        end
        start = 1'b0;
        m_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus0.rdaddr !== 12'h000) begin failures++; $display("[TB] FAIL reset_rdaddr got=%h exp=%h", bus0.rdaddr, 12'h000); end
        checks++; if (bus0.rden !== 1'b0) begin failures++; $display("[TB] FAIL reset_rden got=%b exp=0", bus0.rden); end
        checks++; if (bus0.m_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_mvalid got=%b exp=0", bus0.m_valid); end
        checks++; if (bus0.m_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_mdata got=%h exp=00", bus0.m_data); end
        checks++; if (busy0 !== 1'b0 || busy1 !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b%b exp=00", busy0, busy1); end
        checks++; if (done0 !== 1'b0 || done1 !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b%b exp=00", done0, done1); end
        checks++; if (bus0.regce !== 1'b0 || bus1.regce !== 1'b1) begin failures++; $display("[TB] FAIL reset_regce got=%b%b exp=01", bus0.regce, bus1.regce); end
`ifdef BRAM_RD_CHKSUM_EN
        checks++; if (chk0 !== 8'h00) begin failures++; $display("[TB] FAIL reset_chksum got=%h exp=00", chk0); end
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic check_basic_run(input string tag, input int exp_first, input int exp_done);
        logic [7:0] g;
        checks++; if (timed_out) begin failures++; $display("[TB] FAIL %s_timeout got=1 exp=0", tag); end
        checks++; if (first_valid != exp_first) begin failures++; $display("[TB] FAIL %s_first_valid got=%0d exp=%0d", tag, first_valid, exp_first); end
        checks++; if (done_cyc != exp_done) begin failures++; $display("[TB] FAIL %s_done_cycle got=%0d exp=%0d", tag, done_cyc, exp_done); end
        checks++; if (got_q.size() != 16) begin failures++; $display("[TB] FAIL %s_byte_count got=%0d exp=16", tag, got_q.size()); end
        for (int i = 0; i < 16; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            checks++; if (g !== 8'(8'h10 + i)) begin failures++; $display("[TB] FAIL %s_byte%0d got=%h exp=%h", tag, i, g, 8'(8'h10 + i)); end
        end
        checks++; if (regce_bad != 0) begin failures++; $display("[TB] FAIL %s_regce bad_cycles=%0d exp=0", tag, regce_bad); end
    endtask

    task automatic test_basic();
        int sum;
        sel = 1'b0;
        run_xfer(12'h010, 13'd16, 1'b0, 1'b0, 100);
        check_basic_run("basic", 3, 19);
        checks++; if (busy_cyc != 18) begin failures++; $display("[TB] FAIL basic_busy_cycles got=%0d exp=18", busy_cyc); end
        checks++; if (addr_q.size() != 16 || addr_q[0] !== 12'h010 || addr_q[addr_q.size()-1] !== 12'h01F) begin
            failures++; $display("[TB] FAIL basic_rdaddr count=%0d exp=16 first/last exp=010/01F", addr_q.size());
        end
        sum = 0;
        for (int i = 0; i < 16; i++) sum += 16 + i;
`ifdef BRAM_RD_CHKSUM_EN
        checks++; if (chk0 !== 8'(sum)) begin failures++; $display("[TB] FAIL basic_chksum got=%h exp=%h", chk0, 8'(sum)); end
`endif
    endtask

    task automatic test_do_reg1();
        sel = 1'b1;
        run_xfer(12'h010, 13'd16, 1'b0, 1'b0, 100);
        check_basic_run("doreg1", 4, 20);
        sel = 1'b0;
    endtask

    task automatic test_wrap();
        logic [11:0] exp_a [4];
        logic [7:0]  exp_d [4];
        logic [11:0] a;
        logic [7:0]  g;
        exp_a = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
        exp_d = '{8'h0E, 8'h0F, 8'h00, 8'h01};
        sel = 1'b0;
        run_xfer(12'hFFE, 13'd4, 1'b0, 1'b0, 50);
        checks++; if (done_cyc != 7) begin failures++; $display("[TB] FAIL wrap_done_cycle got=%0d exp=7", done_cyc); end
        for (int i = 0; i < 4; i++) begin
            a = (i < addr_q.size()) ? addr_q[i] : 12'hxxx;
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            checks++; if (a !== exp_a[i]) begin failures++; $display("[TB] FAIL wrap_addr%0d got=%h exp=%h", i, a, exp_a[i]); end
            checks++; if (g !== exp_d[i]) begin failures++; $display("[TB] FAIL wrap_byte%0d got=%h exp=%h", i, g, exp_d[i]); end
        end
    endtask

    task automatic test_random();
        int bad, sum;
        logic [7:0] e;
        sel = 1'b0;
        run_xfer(12'h123, 13'd64, 1'b1, 1'b1, 1000);
        checks++; if (timed_out) begin failures++; $display("[TB] FAIL rand_timeout got=1 exp=0"); end
        checks++; if (got_q.size() != 64) begin failures++; $display("[TB] FAIL rand_byte_count got=%0d exp=64", got_q.size()); end
        checks++; if (addr_q.size() != 64) begin failures++; $display("[TB] FAIL rand_read_count got=%0d exp=64", addr_q.size()); end
        bad = 0; sum = 0;
        for (int i = 0; i < 64; i++) begin
            e = mem_byte(12'(12'h123 + i));
            sum += e;
            if (i >= got_q.size() || got_q[i] !== e) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("[TB] FAIL rand_order bad_bytes=%0d exp=0", bad); end
        checks++; if (credit_viol != 0) begin failures++; $display("[TB] FAIL rand_credit violations=%0d exp=0", credit_viol); end
`ifdef BRAM_RD_CHKSUM_EN
        checks++; if (chk0 !== 8'(sum)) begin failures++; $display("[TB] FAIL rand_chksum got=%h exp=%h", chk0, 8'(sum)); end
`endif
    endtask

    task automatic test_zero_len();
        sel = 1'b0;
        run_xfer(12'h005, 13'd0, 1'b0, 1'b0, 10);
        checks++; if (done_cyc != 1) begin failures++; $display("[TB] FAIL zero_done_cycle got=%0d exp=1", done_cyc); end
        checks++; if (addr_q.size() != 0) begin failures++; $display("[TB] FAIL zero_rden got=%0d exp=0", addr_q.size()); end
        checks++; if (busy_cyc != 0) begin failures++; $display("[TB] FAIL zero_busy got=%0d exp=0", busy_cyc); end
        @(posedge clk); #1;
        checks++; if (done0 !== 1'b0 || bus0.rden !== 1'b0) begin failures++; $display("[TB] FAIL zero_after got done=%b rden=%b exp=0/0", done0, bus0.rden); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d [5];
        logic [7:0] g;
        exp_d = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34};
        sel = 1'b0;
        run_xfer(12'h200, 13'd3, 1'b0, 1'b0, 50);
        checks++; if (done_cyc != 6) begin failures++; $display("[TB] FAIL b2b_first_done got=%0d exp=6", done_cyc); end
        run_xfer(12'h300, 13'd5, 1'b0, 1'b0, 50);
        checks++; if (first_valid != 3) begin failures++; $display("[TB] FAIL b2b_second_first_valid got=%0d exp=3", first_valid); end
        checks++; if (done_cyc != 8) begin failures++; $display("[TB] FAIL b2b_second_done got=%0d exp=8", done_cyc); end
        for (int i = 0; i < 5; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            checks++; if (g !== exp_d[i]) begin failures++; $display("[TB] FAIL b2b_byte%0d got=%h exp=%h", i, g, exp_d[i]); end
        end
    endtask

    task automatic test_reset_abort();
        int hs, cyc, dseen;
        sel = 1'b0;
        base_addr = 12'h040; len = 13'd32; m_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        hs = 0; cyc = 0;
        while (hs < 5 && cyc < 50) begin
            if (bus0.m_valid === 1'b1) hs++;
            if (hs < 5) begin @(posedge clk); #1; cyc++; end
        end
        checks++; if (hs != 5) begin failures++; $display("[TB] FAIL abort_reach_byte5 got=%0d exp=5", hs); end
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checks++; if (bus0.rden !== 1'b0 || bus0.rdaddr !== 12'h000) begin failures++; $display("[TB] FAIL abort_bram got rden=%b addr=%h exp=0/000", bus0.rden, bus0.rdaddr); end
        checks++; if (bus0.m_valid !== 1'b0 || bus0.m_data !== 8'h00) begin failures++; $display("[TB] FAIL abort_stream got valid=%b data=%h exp=0/00", bus0.m_valid, bus0.m_data); end
        checks++; if (busy0 !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy got=%b exp=0", busy0); end
        dseen = 0;
        repeat (3) begin @(posedge clk); #1; if (done0 !== 1'b0) dseen++; end
        rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; if (done0 !== 1'b0 || busy0 !== 1'b0) dseen++; end
        checks++; if (dseen != 0) begin failures++; $display("[TB] FAIL abort_no_done got=%0d exp=0", dseen); end
        run_xfer(12'h050, 13'd2, 1'b0, 1'b0, 50);
        checks++; if (done_cyc != 5) begin failures++; $display("[TB] FAIL abort_restart_done got=%0d exp=5", done_cyc); end
        checks++; if (got_q.size() != 2 || got_q[0] !== 8'h50 || got_q[1] !== 8'h51) begin
            failures++; $display("[TB] FAIL abort_restart_bytes count=%0d exp=2 values exp=50,51", got_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = mem_byte(12'(i));
        rst_n = 1'b0; sel = 1'b0; start = 1'b0; m_ready = 1'b1;
        base_addr = '0; len = '0;
        test_reset();
        test_basic();
        test_do_reg1();
        test_wrap();
        test_random();
        test_zero_len();
        test_back_to_back();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
